mdu_iter: RTL and testbench
===========================

# mdu_iter

Iterative multiply/divide unit on the consuming (`dst`) end of the `alu_ops` decode interface. It executes the RV64 M-extension subset that the decoder encodes as `mul_op`, `mulh_op`, `mulhsu_op`, `div_op` and `rem_op`, qualified by `is_unsign` and `is_word`. It sits beside the single-cycle ALU in the execute stage and uses a valid/ready request and response handshake, so the pipeline stalls while it is busy.

## Interface
- `XLEN`, 64: operand and result width. Only 64 is supported.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ops` in `alu_ops.dst`: decoded operation. Only `mul_op`, `mulh_op`, `mulhsu_op`, `div_op`, `rem_op`, `is_unsign` and `is_word` are used.
- `req_valid` in 1: `ops`, `src1` and `src2` are valid.
- `req_ready` out 1: the unit is IDLE and can accept a request.
- `src1` in 64: rs1 operand (dividend or multiplicand).
- `src2` in 64: rs2 operand (divisor or multiplier).
- `flush` in 1: synchronous kill of any in-flight operation.
- `resp_valid` out 1: `result` is valid.
- `resp_ready` in 1: the consumer takes the result.
- `result` out 64: final value, sign-extended from bit 31 when `is_word` is set.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **States and transitions**
  - IDLE → CALC on accept (`req_valid && req_ready && !flush`).
  - CALC → FIX when the iteration counter reaches 0.
  - FIX → DONE.
  - DONE → IDLE on `resp_valid && resp_ready`.
- **Latched at accept:** `ops`, `src1` and `src2`. Inputs are not sampled again until the next accept.
- **Operand preparation at accept**
  - With `is_word` set, both operands are truncated to 32 bits. They are then sign-extended when the op is signed, else zero-extended.
  - Iteration count N is 32 when `is_word` is set, else 64.
- **Op decode**
  - `mul_op`: low XLEN bits of the product.
  - `mulh_op` with `is_unsign=0`: MULH (signed×signed, high half).
  - `mulh_op` with `is_unsign=1`: MULHU (unsigned×unsigned, high half).
  - `mulhsu_op`: signed src1 × unsigned src2, high half.
  - `div_op` / `rem_op`: signed, or unsigned when `is_unsign=1`.
  - `mul_op` with `is_word`: MULW, the low 32 bits sign-extended.
- **Multiply datapath**
  - Radix-2 shift-add on operand magnitudes, one multiplier bit per CALC cycle, with a 2×XLEN accumulator.
  - FIX negates the product when the operand signs differ (signed ops only), then selects the high or low half.
- **Divide datapath**
  - Restoring division on magnitudes, one quotient bit per CALC cycle.
  - FIX gives the quotient the sign of dividend XOR divisor and the remainder the sign of the dividend.
- **Special cases.** These are detected at accept, bypass CALC, and go IDLE → FIX → DONE.
  - Divisor equals 0: quotient is all ones; remainder equals the dividend (word variants sign-extended).
  - Signed overflow (dividend is the most negative value and divisor is −1): quotient equals the dividend; remainder is 0.
  - No M op set: result is 0.
- **Flush**
  - From any state, the next state is IDLE and `resp_valid` drops on that edge.
  - Flush takes priority over an accept and over a response handshake in the same cycle.
- **Reset values:** state IDLE, `req_ready=1`, `busy=0`, `resp_valid=0`, `result=0`, counter 0.

## Timing
- Accept happens at rising edge T.
- Normal ops: FIX occupies the cycle after edge T+N; `resp_valid` is first high after edge T+N+1.
  - Latency is 65 edges for 64-bit ops and 33 edges for word ops.
- Special cases: `resp_valid` is high after edge T+2.
- **Response hold:** `resp_valid` and `result` stay stable until the handshake edge. `req_ready` returns high on the following cycle; there is no same-cycle back-to-back accept.
- Reset asserted mid-operation forces the reset values immediately, independent of `clk`.

## Test plan
- MUL 64-bit: src1=0xFFFF_FFFF_FFFF_FFFF, src2=2 → result 0xFFFF_FFFF_FFFF_FFFE, `resp_valid` 65 edges after accept.
- MULHU: src1=src2=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE. MULHSU with src1=−1, src2=2 → 0xFFFF_FFFF_FFFF_FFFF.
- DIVW: src1=0x0000_0000_8000_0000, src2=0xFFFF_FFFF_FFFF_FFFF → result 0xFFFF_FFFF_8000_0000. REMW on the same operands → 0. Both arrive 2 edges after accept.
- DIVU with src2=0 → 0xFFFF_FFFF_FFFF_FFFF. REM with src1=−7, src2=0 → 0xFFFF_FFFF_FFFF_FFF9. REM with src1=−7, src2=2 → −1. DIV with −7 / 2 → −3 (33 edges when `is_word` is set).
- Backpressure: hold `resp_ready=0` for 10 cycles after `resp_valid` → `result` stays stable and `req_ready` stays 0. Then pulse `resp_ready` → IDLE on the next edge.
- Flush in CALC cycle 20, with `req_valid` also high that cycle → no accept; IDLE next edge; no `resp_valid`. A fresh MUL 3×5 afterwards returns 15. Asserting `rst` mid-CALC forces `busy=0` and `resp_valid=0` at once.

Source files
------------

// File: rtl/mdu_iter_if.sv
`default_nettype none
// alu_ops: decoded-operation bundle. mdu_iter_if: request/response bus of the iterative MDU.
// Rev 1.0

interface alu_ops;
  logic mul_op;
  logic mulh_op;
  logic mulhsu_op;
  logic div_op;
  logic rem_op;
  logic is_unsign;
  logic is_word;

  modport src (output mul_op, mulh_op, mulhsu_op, div_op, rem_op, is_unsign, is_word);
  modport dst (input  mul_op, mulh_op, mulhsu_op, div_op, rem_op, is_unsign, is_word);
endinterface

interface mdu_iter_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            flush;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output req_valid, src1, src2, flush, resp_ready,
    input  req_ready, resp_valid, result, busy
  );
  modport slave (
    input  req_valid, src1, src2, flush, resp_ready,
    output req_ready, resp_valid, result, busy
  );
endinterface

`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// mdu_iter: iterative RV64M multiply (radix-2 shift-add) / divide (restoring) unit.
// Rev 1.0

module mdu_iter #(
  parameter int XLEN = 64
) (
  input  wire logic clk,
  input  wire logic rst,
  alu_ops.dst       ops,
  mdu_iter_if.slave bus
);
  localparam int         HW     = XLEN / 2;
  localparam logic [6:0] N_FULL = 7'd64;
  localparam logic [6:0] N_WORD = 7'd32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [6:0]        r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_result;
  logic              r_is_div, r_is_rem, r_high, r_word, r_neg, r_special;

  logic              w_is_div, w_no_op, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic              w_div0, w_ovf, w_special, w_accept;
  logic [XLEN-1:0]   w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min_neg, w_spec_val;
  logic              w_req_ready, w_busy, w_resp_valid;

  assign w_is_div = ops.div_op | ops.rem_op;
  assign w_no_op  = ~(ops.mul_op | ops.mulh_op | ops.mulhsu_op | w_is_div);
  // Low product bits do not depend on signedness, so MUL is handled as signed.
  assign w_a_sgn  = ops.mul_op | ops.mulhsu_op | ((ops.mulh_op | w_is_div) & ~ops.is_unsign);
  assign w_b_sgn  = ops.mul_op | ((ops.mulh_op | w_is_div) & ~ops.is_unsign);

  assign w_a_ext  = ops.is_word ? {{HW{w_a_sgn & bus.src1[HW-1]}}, bus.src1[HW-1:0]} : bus.src1;
  assign w_b_ext  = ops.is_word ? {{HW{w_b_sgn & bus.src2[HW-1]}}, bus.src2[HW-1:0]} : bus.src2;
  assign w_a_neg  = w_a_sgn & w_a_ext[XLEN-1];
  assign w_b_neg  = w_b_sgn & w_b_ext[XLEN-1];
  assign w_a_mag  = w_a_neg ? -w_a_ext : w_a_ext;
  assign w_b_mag  = w_b_neg ? -w_b_ext : w_b_ext;

  assign w_min_neg = ops.is_word ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
  assign w_div0    = (w_b_ext == '0);
  assign w_ovf     = w_a_sgn & (w_a_ext == w_min_neg) & (w_b_ext == '1);
  assign w_special = w_no_op | (w_is_div & (w_div0 | w_ovf));
  assign w_accept  = bus.req_valid & (r_state == S_IDLE) & ~bus.flush;

  always_comb begin
    w_spec_val = '0;
    if (w_no_op)     w_spec_val = '0;
    else if (w_div0) w_spec_val = ops.rem_op ? w_a_ext : '1;
    else if (w_ovf)  w_spec_val = ops.rem_op ? '0 : w_a_ext;
  end

  // One iteration: multiply adds into the upper half and shifts right, divide shifts left.
  logic [XLEN:0]     w_mul_sum, w_div_diff;
  logic [2*XLEN-1:0] w_mul_step, w_div_step;

  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_step = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_div_diff = {r_acc[2*XLEN-1:XLEN-1]} - {1'b0, r_b};
  assign w_div_step = w_div_diff[XLEN]
                    ? {r_acc[2*XLEN-2:XLEN-1], r_acc[XLEN-2:0], 1'b0}
                    : {w_div_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_quo, w_rem, w_raw, w_fix_res;

  // Word multiplies stop after 32 shifts, leaving the product 32 bits too high.
  assign w_prod    = r_word ? {{HW{1'b0}}, r_acc[2*XLEN-1:HW]} : r_acc;
  assign w_prod_s  = r_neg ? -w_prod : w_prod;
  assign w_quo     = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem     = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
  assign w_raw     = r_special ? r_acc[XLEN-1:0]
                   : r_is_div  ? (r_is_rem ? w_rem : w_quo)
                   : (r_high ? w_prod_s[2*XLEN-1:XLEN] : w_prod_s[XLEN-1:0]);
  assign w_fix_res = r_word ? {{HW{w_raw[HW-1]}}, w_raw[HW-1:0]} : w_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_req_ready  = 1'b0;
    w_busy       = 1'b1;
    w_resp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        w_busy      = 1'b0;
        if (w_accept) w_next = w_special ? S_FIX : S_CALC;
      end
      S_CALC: if (r_cnt == 7'd1) w_next = S_FIX;
      S_FIX:  if (r_cnt == 7'd0) w_next = S_DONE;
      S_DONE: begin
        w_resp_valid = 1'b1;
        if (bus.resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (bus.flush) w_next = S_IDLE;
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.busy       = w_busy;
  assign bus.resp_valid = w_resp_valid;
  assign bus.result     = r_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_is_div  <= 1'b0;
      r_is_rem  <= 1'b0;
      r_high    <= 1'b0;
      r_word    <= 1'b0;
      r_neg     <= 1'b0;
      r_special <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_div  <= w_is_div;
            r_is_rem  <= ops.rem_op;
            r_high    <= ops.mulh_op | ops.mulhsu_op;
            r_word    <= ops.is_word;
            r_special <= w_special;
            r_neg     <= ops.rem_op ? w_a_neg : (w_a_neg ^ w_b_neg);
            r_b       <= w_is_div ? w_b_mag : w_a_mag;
            // Specials hold FIX for two cycles so their response lands two edges after accept.
            r_cnt     <= w_special ? 7'd1 : (ops.is_word ? N_WORD : N_FULL);
            if (w_special)
              r_acc <= {{XLEN{1'b0}}, w_spec_val};
            else if (w_is_div)
              r_acc <= {{XLEN{1'b0}}, (ops.is_word ? {w_a_mag[HW-1:0], {HW{1'b0}}} : w_a_mag)};
            else
              r_acc <= {{XLEN{1'b0}}, w_b_mag};
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            r_cnt <= '0;
          end else begin
            r_acc <= r_is_div ? w_div_step : w_mul_step;
            r_cnt <= r_cnt - 7'd1;
          end
        end
        S_FIX: begin
          r_result <= w_fix_res;
          if (r_cnt != 7'd0) r_cnt <= r_cnt - 7'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// tb_mdu_iter: directed vector table plus handshake, flush and reset sequences for mdu_iter.
// Rev 1.0

module tb_mdu_iter;
  localparam logic [6:0] OP_MUL    = 7'b1000000;
  localparam logic [6:0] OP_MULH   = 7'b0100000;
  localparam logic [6:0] OP_MULHSU = 7'b0010000;
  localparam logic [6:0] OP_DIV    = 7'b0001000;
  localparam logic [6:0] OP_REM    = 7'b0000100;
  localparam logic [6:0] F_U       = 7'b0000010;
  localparam logic [6:0] F_W       = 7'b0000001;
  localparam int         NV        = 17;

  typedef struct {
    logic [6:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_ops     u_ops ();
  mdu_iter_if u_bus ();

  mdu_iter #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .ops (u_ops),
    .bus (u_bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_ops(input logic [6:0] op);
    {u_ops.mul_op, u_ops.mulh_op, u_ops.mulhsu_op, u_ops.div_op,
     u_ops.rem_op, u_ops.is_unsign, u_ops.is_word} = op;
  endtask

  // Entered and left at posedge+1; lat counts edges from the accept edge to first resp_valid.
  task automatic run_op(input logic [6:0] op, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat);
    set_ops(op);
    u_bus.src1      = a;
    u_bus.src2      = b;
    u_bus.req_valid = 1'b1;
    @(posedge clk); #1;
    u_bus.req_valid = 1'b0;
    set_ops(7'b0);
    u_bus.src1 = ~a;
    u_bus.src2 = ~b;
    lat = 0;
    while (!u_bus.resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = u_bus.result;
  endtask

  task automatic respond(input string name);
    u_bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    u_bus.resp_ready = 1'b0;
    check({name, " resp_valid after handshake"}, 64'(u_bus.resp_valid), 64'd0);
    check({name, " req_ready after handshake"}, 64'(u_bus.req_ready), 64'd1);
  endtask

  vec_t        vecs [NV];
  logic [63:0] res;
  int          lat;
  int          seen;

  initial begin
    vecs[0]  = '{OP_MUL,          64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[1]  = '{OP_MULH | F_U,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[2]  = '{OP_MULHSU,       64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[3]  = '{OP_MULH,         64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   65};
    vecs[4]  = '{OP_MULH,         64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 65};
    vecs[5]  = '{OP_DIV | F_W,    64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2};
    vecs[6]  = '{OP_REM | F_W,    64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   2};
    vecs[7]  = '{OP_DIV | F_U,    64'h1234_5678_9ABC_DEF0, 64'h0,                   64'hFFFF_FFFF_FFFF_FFFF, 2};
    vecs[8]  = '{OP_REM,          64'hFFFF_FFFF_FFFF_FFF9, 64'h0,                   64'hFFFF_FFFF_FFFF_FFF9, 2};
    vecs[9]  = '{OP_REM,          64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[10] = '{OP_DIV | F_W,    64'h1234_5678_FFFF_FFF9, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFD, 33};
    vecs[11] = '{OP_MUL | F_W,    64'h0000_0000_7FFF_FFFF, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[12] = '{OP_MUL | F_W,    64'd3,                   64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 33};
    vecs[13] = '{OP_DIV,          64'd100,                 64'd7,                   64'd14,                  65};
    vecs[14] = '{OP_REM | F_U,    64'd100,                 64'd7,                   64'd2,                   65};
    vecs[15] = '{OP_DIV,          64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2};
    vecs[16] = '{7'b0,            64'd5,                   64'd6,                   64'h0,                   2};

    rst              = 1'b1;
    u_bus.req_valid  = 1'b0;
    u_bus.src1       = '0;
    u_bus.src2       = '0;
    u_bus.flush      = 1'b0;
    u_bus.resp_ready = 1'b0;
    set_ops(7'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready",  64'(u_bus.req_ready),  64'd1);
    check("reset busy",       64'(u_bus.busy),       64'd0);
    check("reset resp_valid", 64'(u_bus.resp_valid), 64'd0);
    check("reset result",     u_bus.result,          64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d result", i), res, vecs[i].exp);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      respond($sformatf("vec%0d", i));
    end

    // Backpressure: response must hold for 10 stalled cycles.
    run_op(OP_MUL, 64'd6, 64'd7, res, lat);
    check("bp result", res, 64'd42);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold result c%0d", i), u_bus.result, 64'd42);
      check($sformatf("bp hold req_ready c%0d", i), 64'(u_bus.req_ready), 64'd0);
      check($sformatf("bp hold resp_valid c%0d", i), 64'(u_bus.resp_valid), 64'd1);
    end
    respond("bp");

    // Flush in CALC cycle 20 with a competing request.
    set_ops(OP_MUL);
    u_bus.src1      = 64'd9;
    u_bus.src2      = 64'd9;
    u_bus.req_valid = 1'b1;
    @(posedge clk); #1;
    u_bus.req_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    u_bus.flush     = 1'b1;
    u_bus.req_valid = 1'b1;
    @(posedge clk); #1;
    u_bus.flush     = 1'b0;
    u_bus.req_valid = 1'b0;
    set_ops(7'b0);
    check("flush busy",       64'(u_bus.busy),       64'd0);
    check("flush req_ready",  64'(u_bus.req_ready),  64'd1);
    check("flush resp_valid", 64'(u_bus.resp_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (u_bus.resp_valid || u_bus.busy) seen++;
    end
    check("flush no later activity", 64'(seen), 64'd0);
    run_op(OP_MUL, 64'd3, 64'd5, res, lat);
    check("post-flush mul result", res, 64'd15);
    check("post-flush mul latency", 64'(lat), 64'd65);
    respond("post-flush");

    // Asynchronous reset in the middle of CALC.
    set_ops(OP_DIV);
    u_bus.src1      = 64'd100;
    u_bus.src2      = 64'd7;
    u_bus.req_valid = 1'b1;
    @(posedge clk); #1;
    u_bus.req_valid = 1'b0;
    set_ops(7'b0);
    repeat (10) @(posedge clk);
    #3;
    check("pre-reset busy", 64'(u_bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    check("async reset busy",       64'(u_bus.busy),       64'd0);
    check("async reset resp_valid", 64'(u_bus.resp_valid), 64'd0);
    check("async reset req_ready",  64'(u_bus.req_ready),  64'd1);
    check("async reset result",     u_bus.result,          64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(OP_DIV, 64'd100, 64'd7, res, lat);
    check("post-reset div result", res, 64'd14);
    check("post-reset div latency", 64'(lat), 64'd65);
    respond("post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
